// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 serial transmitter (LSB first).
// The CPU port pushes bytes into the FIFO. The FSM pops the head byte when a frame starts.
// Status for port polling: txready (FIFO not full), busy (frame running or bytes pending),
// and a sticky ovf flag that records a write dropped because the FIFO was full.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 3
) (
  input  logic               m_clock,
  input  logic               p_reset,
  input  logic [7:0]         data,
  input  logic               port_write,
  input  logic               clr_ovf,
  output logic               txready,
  output logic               busy,
  output logic               ovf,
  output logic [FIFO_AW:0]   count,
  output logic               txd
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0]      BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]      BAUD_ONE  = BW'(1);
  localparam logic [FIFO_AW:0]   DEPTH_C   = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e               state_q;
  logic [BW-1:0]        baud_q;
  logic [2:0]           bit_q;
  logic [7:0]           shift_q;
  logic                 txd_q;

  logic [7:0]           mem_q [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;

  logic                 full_s;
  logic                 push_s;
  logic                 drop_s;
  logic                 pop_s;
  logic                 baud_done_s;

  // FIFO control: fullness is judged on the pre-edge count, so a write while full is dropped even if a pop happens on the same edge
  always_comb begin
    full_s      = (count_q == DEPTH_C);
    push_s      = port_write && !full_s;
    drop_s      = port_write && full_s;
    baud_done_s = (baud_q == BAUD_LAST);
    pop_s       = 1'b0;
    case (state_q)
      S_IDLE:  pop_s = (count_q != '0);
      S_STOP:  pop_s = baud_done_s && (count_q != '0);
      default: pop_s = 1'b0;
    endcase
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers, so no reset is needed
  always_ff @(posedge m_clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  // Frame sequencer; txd is registered from the current state, so it lags each state change by one edge
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      txd_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          txd_q <= 1'b1;
          if (pop_s) begin
            shift_q <= mem_q[rd_ptr_q];
            baud_q  <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          txd_q <= 1'b0;
          if (baud_done_s) begin
            baud_q  <= '0;
            bit_q   <= 3'd0;
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        S_DATA: begin
          txd_q <= shift_q[0];
          if (baud_done_s) begin
            baud_q  <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        S_STOP: begin
          txd_q <= 1'b1;
          if (baud_done_s) begin
            baud_q <= '0;
            if (pop_s) begin
              shift_q <= mem_q[rd_ptr_q];
              state_q <= S_START;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        default: begin
          txd_q   <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign txready = (count_q != DEPTH_C);
  assign busy    = (state_q != S_IDLE) || (count_q != '0);
  assign ovf     = ovf_q;
  assign count   = count_q;
  assign txd     = txd_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a queue-based reference model predicts the line and status.
// Expected txd is derived from the time elapsed since a frame started.
module tb_uart_tx_fifo;

  localparam int CPB   = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          m_clock;
  logic          p_reset;
  logic [7:0]    data;
  logic          port_write;
  logic          clr_ovf;
  logic          txready;
  logic          busy;
  logic          ovf;
  logic [AW:0]   count;
  logic          txd;

  int checks = 0;
  int passes = 0;

  // reference model state
  logic [7:0] fifo_m [$];
  int         cyc    = 0;
  bit         active = 0;
  int         fstart = 0;
  logic [7:0] fbyte  = 8'h00;
  logic       m_ovf  = 1'b0;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .m_clock    (m_clock),
    .p_reset    (p_reset),
    .data       (data),
    .port_write (port_write),
    .clr_ovf    (clr_ovf),
    .txready    (txready),
    .busy       (busy),
    .ovf        (ovf),
    .count      (count),
    .txd        (txd)
  );

  initial m_clock = 1'b0;
  always #5 m_clock = ~m_clock;

  task automatic model_reset();
    fifo_m.delete();
    active = 0;
    m_ovf  = 1'b0;
  endtask

  // one rising edge of the reference: frames occupy 10*CPB edges counted from the pop edge
  task automatic model_edge();
    int  pre;
    bit  full;
    bit  do_pop;
    if (!p_reset) begin
      model_reset();
      return;
    end
    cyc    = cyc + 1;
    pre    = fifo_m.size();
    full   = (pre == DEPTH);
    do_pop = 0;
    if (!active) begin
      if (pre > 0) do_pop = 1;
    end else if (cyc - fstart == 10 * CPB) begin
      if (pre > 0) do_pop = 1;
      else active = 0;
    end
    if (do_pop) begin
      fbyte  = fifo_m.pop_front();
      active = 1;
      fstart = cyc;
    end
    if (port_write && !full) fifo_m.push_back(data);
    if (port_write && full) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
  endtask

  function automatic logic exp_txd();
    int e;
    int idx;
    if (!active) return 1'b1;
    e = cyc - fstart;
    if (e < 1) return 1'b1;
    idx = (e - 1) / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return fbyte[idx-1];
    return 1'b1;
  endfunction

  // expected {txd, busy, txready, ovf, count}
  function automatic logic [AW+4:0] expv();
    logic [AW:0] c;
    c = (AW + 1)'(fifo_m.size());
    return {exp_txd(), (active || fifo_m.size() != 0), (fifo_m.size() != DEPTH), m_ovf, c};
  endfunction

  function automatic logic [AW+4:0] obsv();
    return {txd, busy, txready, ovf, count};
  endfunction

  // advance one clock: model follows the rising edge, caller resumes at the falling edge
  task automatic step();
    @(posedge m_clock);
    model_edge();
    @(negedge m_clock);
  endtask

  task automatic test_reset();
    p_reset = 1'b0;
    repeat (3) step();
    p_reset = 1'b1;
    for (int k = 0; k < 200; k++) begin
      step();
      checks++;
      if (obsv() !== {1'b1, 1'b0, 1'b1, 1'b0, (AW+1)'(0)})
        $display("FAIL reset_idle k=%0d got txd/busy/rdy/ovf/cnt=%b expected %b", k, obsv(), {1'b1, 1'b0, 1'b1, 1'b0, (AW+1)'(0)});
      else passes++;
    end
  endtask

  task automatic test_single();
    logic s [0:179];
    int fall = -1;
    int lastbusy = -1;
    logic [7:0] rx;
    data = 8'h41; port_write = 1'b1;
    step();
    port_write = 1'b0;
    s[0] = txd;
    for (int k = 1; k < 180; k++) begin
      step();
      s[k] = txd;
      if (busy) lastbusy = k;
      if (txd == 1'b0 && fall < 0) fall = k;
      checks++;
      if (obsv() !== expv()) $display("FAIL single_line k=%0d got %b expected %b", k, obsv(), expv());
      else passes++;
    end
    checks++;
    if (fall !== 2) $display("FAIL single_start_latency got %0d expected 2", fall); else passes++;
    checks++;
    if ({s[17], s[18]} !== 2'b01) $display("FAIL single_start_end got %b expected 01", {s[17], s[18]}); else passes++;
    checks++;
    if (lastbusy !== 160) $display("FAIL single_busy_end got %0d expected 160", lastbusy); else passes++;
    for (int i = 0; i < 8; i++) rx[i] = s[2 + CPB * (i + 1) + CPB / 2];
    checks++;
    if (rx !== 8'h41) $display("FAIL single_decode got %h expected 41", rx); else passes++;
    checks++;
    if ({s[2 + CPB / 2], s[2 + 9 * CPB + CPB / 2]} !== 2'b01)
      $display("FAIL single_framing got %b expected 01", {s[2 + CPB / 2], s[2 + 9 * CPB + CPB / 2]});
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic s [0:339];
    int lastbusy = -1;
    int peak = 0;
    data = 8'h48; port_write = 1'b1;
    step();
    data = 8'h69;
    step();
    port_write = 1'b0;
    for (int k = 2; k < 340; k++) begin
      step();
      s[k] = txd;
      if (busy) lastbusy = k;
      if (int'(count) > peak) peak = int'(count);
      checks++;
      if (obsv() !== expv()) $display("FAIL b2b_line k=%0d got %b expected %b", k, obsv(), expv());
      else passes++;
    end
    checks++;
    if ({s[161], s[162]} !== 2'b10) $display("FAIL b2b_no_gap got %b expected 10", {s[161], s[162]}); else passes++;
    checks++;
    if (lastbusy !== 320) $display("FAIL b2b_busy_end got %0d expected 320", lastbusy); else passes++;
    checks++;
    if (peak !== 1) $display("FAIL b2b_count_peak got %0d expected 1", peak); else passes++;
  endtask

  task automatic test_fill_ovf();
    port_write = 1'b1;
    for (int i = 0; i < 9; i++) begin
      data = 8'(8'h30 + i);
      step();
      checks++;
      if (obsv() !== expv()) $display("FAIL fill_line i=%0d got %b expected %b", i, obsv(), expv());
      else passes++;
    end
    checks++;
    if ({txready, count} !== {1'b0, (AW+1)'(8)}) $display("FAIL fill_full got rdy/cnt=%b expected 0_1000", {txready, count}); else passes++;
    data = 8'h39;
    step();
    port_write = 1'b0;
    checks++;
    if ({ovf, count} !== {1'b1, (AW+1)'(8)}) $display("FAIL fill_drop got ovf/cnt=%b expected 1_1000", {ovf, count}); else passes++;
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    checks++;
    if (ovf !== 1'b0) $display("FAIL fill_clr_ovf got %b expected 0", ovf); else passes++;
  endtask

  task automatic test_pop_collision();
    int n = 0;
    while (!(active && (cyc - fstart == 10 * CPB - 1)) && n < 400) begin
      step();
      n++;
      checks++;
      if (obsv() !== expv()) $display("FAIL coll_wait_line got %b expected %b", obsv(), expv());
      else passes++;
    end
    checks++;
    if (n >= 400 || count !== (AW+1)'(8)) $display("FAIL coll_setup got cnt=%0d waited=%0d expected cnt=8", count, n); else passes++;
    data = 8'hEE; port_write = 1'b1;
    step();
    port_write = 1'b0;
    checks++;
    if ({ovf, count} !== {1'b1, (AW+1)'(7)}) $display("FAIL coll_drop got ovf/cnt=%b expected 1_0111", {ovf, count}); else passes++;
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    n = 0;
    while ((busy || active) && n < 3000) begin
      step();
      n++;
      checks++;
      if (obsv() !== expv()) $display("FAIL coll_drain_line got %b expected %b", obsv(), expv());
      else passes++;
    end
    checks++;
    if (n >= 3000) $display("FAIL coll_drain_timeout got busy=%b expected 0", busy); else passes++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    data = 8'h55; port_write = 1'b1;
    step();
    data = 8'h56;
    step();
    port_write = 1'b0;
    while (!(active && (cyc - fstart >= 3 * CPB + 5)) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (count !== (AW+1)'(1)) $display("FAIL rstmid_pending got %0d expected 1", count); else passes++;
    #2 p_reset = 1'b0;
    #1;
    checks++;
    if ({txd, busy, count} !== {1'b1, 1'b0, (AW+1)'(0)})
      $display("FAIL rstmid_async got txd/busy/cnt=%b expected 1_0_0000", {txd, busy, count});
    else passes++;
    model_reset();
    step();
    p_reset = 1'b1;
    for (int k = 0; k < 200; k++) begin
      step();
      checks++;
      if (obsv() !== {1'b1, 1'b0, 1'b1, 1'b0, (AW+1)'(0)})
        $display("FAIL rstmid_after k=%0d got %b expected idle", k, obsv());
      else passes++;
    end
  endtask

  task automatic test_random();
    int hi = 0;
    int n = 0;
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) hi = $urandom_range(0, 1);
      port_write = hi ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 39) == 0);
      data       = 8'($urandom);
      clr_ovf    = ($urandom_range(0, 31) == 0);
      step();
      checks++;
      if (obsv() !== expv()) $display("FAIL random_line k=%0d got %b expected %b", k, obsv(), expv());
      else passes++;
    end
    port_write = 1'b0;
    clr_ovf    = 1'b0;
    while ((busy || active) && n < 3000) begin
      step();
      n++;
      checks++;
      if (obsv() !== expv()) $display("FAIL random_drain_line got %b expected %b", obsv(), expv());
      else passes++;
    end
    checks++;
    if (n >= 3000) $display("FAIL random_drain_timeout got busy=%b expected 0", busy); else passes++;
  endtask

  initial begin
    p_reset    = 1'b0;
    data       = 8'h00;
    port_write = 1'b0;
    clr_ovf    = 1'b0;
    model_reset();
    @(negedge m_clock);
    test_reset();
    test_single();
    test_back_to_back();
    test_fill_ovf();
    test_pop_collision();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
